// File: rtl/ff_pipeline.sv
// Elastic register pipeline: DEPTH valid/data stages joined by a combinational
// ready chain, with bubble collapsing, synchronous flush and an occupancy count.
module ff_pipeline #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CW        = $clog2(DEPTH + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Flush,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [CW-1:0]    Count
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH-1:0] en;
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             accept, pop;

    // A stage may load when it is empty or when the stage ahead of it is moving.
    always_comb begin
        en = '0;
        en[DEPTH-1] = !v_q[DEPTH-1] || Out_Ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            en[k] = !v_q[k] || en[k+1];
        end
    end

    assign In_Ready = en[0] && !Flush;
    assign accept   = In_Valid && In_Ready;
    assign pop      = v_q[DEPTH-1] && Out_Ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
        if (gi == 0) begin : g_head
            assign src_v[gi] = accept;
            assign src_d[gi] = In_Data;
        end else begin : g_body
            assign src_v[gi] = v_q[gi-1];
            assign src_d[gi] = d_q[gi-1];
        end
    end

    always_comb begin
        v_d     = v_q;
        d_d     = d_q;
        count_d = count_q;
        if (Flush) begin
            v_d     = '0;
            count_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_d[k] = RESET_VAL;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (en[k]) begin
                    v_d[k] = src_v[k];
                    // Data only moves with a valid token so empty stages keep their last value.
                    if (src_v[k]) begin
                        d_d[k] = src_d[k];
                    end
                end
            end
            count_d = count_q + CW'(accept) - CW'(pop);
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            v_q     <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d_q[k] <= RESET_VAL;
            end
        end else begin
            v_q     <= v_d;
            d_q     <= d_d;
            count_q <= count_d;
        end
    end

    assign Out_Valid = v_q[DEPTH-1];
    assign Out_Data  = d_q[DEPTH-1];
    assign Count     = count_q;

endmodule

// File: tb/tb_ff_pipeline.sv
// Scoreboard bench for ff_pipeline: accepted items are queued with their accept
// edge; an independent monitor checks every pop, the occupancy and the latency.
module tb_ff_pipeline;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RVAL = 8'h00;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Flush = 1'b0;
    logic [WIDTH-1:0] In_Data = '0;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [WIDTH-1:0] Out_Data;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
    logic [CW-1:0]    Count;

    ff_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RVAL)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .Out_Data(Out_Data), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Count(Count)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               e;
    } item_t;

    item_t exp_q[$];
    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    bit    lat_check = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge Clk) cyc <= cyc + 1;

    // Flush empties the reference at the edge it takes effect.
    always @(posedge Clk) if (Rst && Flush) exp_q.delete();

    // Monitor: occupancy and output order are checked independently of the driver.
    always begin
        item_t it;
        int    expc;
        bit    acc;
        @(negedge Clk);
        #1;
        if (Rst) begin
            acc  = In_Valid && In_Ready;
            expc = exp_q.size() - int'(acc);
            chk("count", 32'(Count), 32'(expc));
            if (Out_Valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(Out_Valid), 32'd0);
                end else begin
                    chk("out_data", 32'(Out_Data), 32'(exp_q[0].d));
                    if (Out_Ready) begin
                        it = exp_q.pop_front();
                        $display("pop  0x%02h at edge %0d", it.d, cyc + 1);
                        if (lat_check) chk("latency", 32'(cyc + 1 - it.e), 32'(DEPTH));
                    end
                end
            end
        end
    end

    // One cycle of stimulus; records the item if the coming edge accepts it.
    task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic ordy,
                         input logic fl, output bit acc);
        @(posedge Clk);
        #1;
        In_Valid  = iv;
        In_Data   = d;
        Out_Ready = ordy;
        Flush     = fl;
        @(negedge Clk);
        acc = Rst && In_Valid && In_Ready;
        if (acc) begin
            exp_q.push_back('{d: d, e: cyc + 1});
            $display("push 0x%02h at edge %0d", d, cyc + 1);
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input logic ordy, input int maxc, output bit ok);
        bit acc;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            drive(1'b1, d, ordy, 1'b0, acc);
            if (acc) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, '0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || Count != 0) && guard < 40) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_count", 32'(Count), 32'd0);
    endtask

    initial begin
        bit ok;
        bit acc;

        #1;
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_data", 32'(Out_Data), 32'(RVAL));
        chk("rst_count", 32'(Count), 32'd0);
        repeat (2) @(posedge Clk);
        #3 Rst = 1'b1;
        #1 chk("rst_in_ready", 32'(In_Ready), 32'd1);

        // Stream with no stall: fixed latency and steady occupancy.
        lat_check = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(8'(i), 1'b1, 10, ok);
            chk("stream_accept", 32'(ok), 32'd1);
            if (i >= 5) chk("stream_count", 32'(Count), 32'd4);
        end
        drain();
        lat_check = 1'b0;

        // Backpressure: four fit, the fifth waits until the consumer resumes.
        for (int i = 0; i < 4; i++) begin
            send(8'h11 + 8'(i), 1'b0, 10, ok);
            chk("bp_accept", 32'(ok), 32'd1);
        end
        send(8'h15, 1'b0, 3, ok);
        chk("bp_held_off", 32'(ok), 32'd0);
        chk("bp_in_ready", 32'(In_Ready), 32'd0);
        chk("bp_count", 32'(Count), 32'd4);
        send(8'h15, 1'b1, 10, ok);
        chk("bp_release", 32'(ok), 32'd1);
        drain();

        // Bubble collapse while the output is stalled.
        send(8'hA0, 1'b0, 10, ok);
        idle(2, 1'b0);
        send(8'hB0, 1'b0, 10, ok);
        idle(6, 1'b0);
        chk("bubble_count", 32'(Count), 32'd2);
        chk("bubble_stage3", 32'(dut.d_q[3]), 32'hA0);
        chk("bubble_stage2", 32'(dut.d_q[2]), 32'hB0);
        idle(1, 1'b1);
        chk("bubble_first", 32'(Out_Valid), 32'd1);
        idle(1, 1'b1);
        chk("bubble_b2b", 32'(Out_Valid), 32'd1);
        drain();

        // Full pipeline with accept and pop on the same edge.
        for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0, 10, ok);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'hD0 + 8'(i), 1'b1, 1'b0, acc);
            chk("full_in_ready", 32'(In_Ready), 32'd1);
            chk("full_count", 32'(Count), 32'd4);
        end

        // Flush while full with an offered item.
        drive(1'b1, 8'h77, 1'b0, 1'b1, acc);
        chk("flush_in_ready", 32'(In_Ready), 32'd0);
        chk("flush_no_accept", 32'(acc), 32'd0);
        idle(1, 1'b0);
        chk("flush_count", 32'(Count), 32'd0);
        chk("flush_out_valid", 32'(Out_Valid), 32'd0);
        chk("flush_out_data", 32'(Out_Data), 32'(RVAL));

        // Asynchronous reset with three items inside.
        for (int i = 0; i < 3; i++) send(8'h31 + 8'(i), 1'b0, 10, ok);
        @(posedge Clk);
        #3;
        Rst = 1'b0;
        In_Valid = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 32'(Out_Valid), 32'd0);
        chk("arst_out_data", 32'(Out_Data), 32'(RVAL));
        chk("arst_count", 32'(Count), 32'd0);
        @(posedge Clk);
        #3 Rst = 1'b1;
        #1 chk("arst_in_ready", 32'(In_Ready), 32'd1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 5),
                  ($urandom_range(0, 39) == 0), acc);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ff_pipeline.md
# ff_pipeline

Parametrised register pipeline of DEPTH stages, each WIDTH bits wide, with a valid/ready handshake on both sides, per-stage bubble collapsing, a synchronous flush and an occupancy count. It generalises the single D flip-flop into a multi-bit, multi-stage storage element. It sits between a producer and a consumer that may stall, for example a retiming or elastic delay stage in a datapath.

## Interface
- WIDTH, 8: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- RESET_VAL, 0: value of every stage data register after reset or flush (WIDTH bits).

- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-low reset. Rst=0 resets immediately, regardless of Clk.
- Flush  in  1  synchronous clear of all stages; active high.
- In_Data  in  WIDTH  upstream data.
- In_Valid  in  1  upstream data is valid.
- In_Ready  out  1  pipeline accepts In_Data this cycle.
- Out_Data  out  WIDTH  data in the last stage.
- Out_Valid  out  1  the last stage holds valid data.
- Out_Ready  in  1  downstream accepts Out_Data this cycle.
- Count  out  $clog2(DEPTH+1)  number of valid stages, registered.

## Operation
- Stage k (0 = input side, DEPTH-1 = output side) holds V[k] and D[k].
- Stage enable:
  - For stage DEPTH-1: En[DEPTH-1] = !V[DEPTH-1] || Out_Ready.
  - For k < DEPTH-1: En[k] = !V[k] || En[k+1].
  - This is a combinational ready chain across all stages.
- In_Ready = En[0] && !Flush.
- Accept: a transfer occurs on an edge where In_Valid && In_Ready.
- Pop: a transfer occurs on an edge where Out_Valid && Out_Ready.
- On each edge where En[k]=1:
  - V[k] <= the valid of the source stage (In_Valid && In_Ready for k=0).
  - D[k] <= the source data, loaded only when the source valid is 1; otherwise D[k] holds.
- Bubble collapsing: an empty stage always advances, so a stalled output lets later items close gaps until all stages are full.
- Order is strictly preserved. Data is never duplicated or dropped, except by Flush.
- Out_Valid = V[DEPTH-1]; Out_Data = D[DEPTH-1].
- Count:
  - If no flush: Count_next = Count + accept − pop.
  - Count always equals the number of set V bits.
- Flush=1 has priority over everything:
  - All V cleared and all D set to RESET_VAL at the edge.
  - The input is not accepted that cycle (In_Ready=0).
  - Count becomes 0.
  - A pop handshake presented in the same cycle is still considered completed by the consumer, since the data was visible.
- Reset values, while Rst=0: all V=0, all D=RESET_VAL, Out_Valid=0, Out_Data=RESET_VAL, Count=0. Consequently In_Ready=1 once Flush=0.
- Reset mid-operation: contents are lost immediately, without waiting for an edge.

## Timing
- Latency: an item accepted at edge t with no stall appears on Out_Valid/Out_Data after edge t+DEPTH−1 and is poppable at edge t+DEPTH.
- Throughput: one item per cycle when Out_Ready=1.
- Full: all V=1 and Out_Ready=0 gives In_Ready=0.
- Full with Out_Ready=1: In_Ready=1, and a simultaneous accept and pop leaves Count unchanged.
- Empty: Out_Valid=0; Out_Ready is ignored.
- In_Ready depends combinationally on Out_Ready through DEPTH stages.
- All outputs except In_Ready are registered.

## Test plan
- Reset: assert Rst=0 between clock edges while the pipeline holds 3 items → Out_Valid=0, Out_Data=0x00, Count=0 immediately. After release, In_Ready=1.
- Stream (WIDTH=8, DEPTH=4, Out_Ready=1): push 0x01..0x0A on consecutive cycles → 0x01 is popped 4 edges after its accept. Then one item per cycle, in order, with Count steady at 4 during the steady state.
- Backpressure (Out_Ready=0): offer 0x11..0x15 → 4 accepted, In_Ready=0, 0x15 held off, Count=4. Raise Out_Ready → 0x11..0x15 emerge in order.
- Bubble collapse (Out_Ready=0): push 0xA0, idle 2 cycles, push 0xB0 → after settling, Count=2 with 0xA0 in stage 3 and 0xB0 in stage 2. Releasing Out_Ready yields 0xA0 then 0xB0 back-to-back.
- Simultaneous accept and pop when full (Out_Ready=1, In_Valid=1) → In_Ready=1 and Count stays 4 across 5 cycles.
- Flush while full with In_Valid=1 → the next cycle shows Count=0, Out_Valid=0, Out_Data=RESET_VAL, and the offered item is not accepted.
